// File: rtl/recv_packet_buffer.sv
// Receive packet buffer: circular FIFO of 32-bit network words, read by the Nios through an
// offset/toggle address PIO. Optional destination filtering is enabled with RECV_DEST_FILTER_EN.
module recv_packet_buffer #(
    parameter int          DEPTH   = 16,
    parameter logic [3:0]  NODE_ID = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic [7:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        pk_avail,
    output logic        overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic          pop_tog_q;
    logic [7:0]    drop_cnt;
    logic [31:0]   in_q;
    logic          in_valid_q;

    logic          in_accept;
    logic          full;
    logic          empty;
    logic          pop_req;
    logic          do_push;
    logic          do_pop;
    logic          drop;
    logic [6:0]    off;
    logic [7:0]    rd_sum;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_mux;

`ifdef RECV_DEST_FILTER_EN
    assign in_accept = in_valid && (in_data[31:28] == NODE_ID);
`else
    localparam logic [3:0] unused_node_id = NODE_ID;
    assign in_accept = in_valid;
`endif

    // Words land one cycle after capture; a pop on a full FIFO frees the slot the push needs.
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign pop_req = rd_addr[7] ^ pop_tog_q;
    assign do_pop  = pop_req && !empty;
    assign do_push = in_valid_q && (!full || pop_req);
    assign drop    = in_valid_q && full && !pop_req;

    assign off    = rd_addr[6:0];
    assign rd_sum = 8'(head) + 8'(off);
    assign rd_idx = rd_sum[AW-1:0];

    always_comb begin
        // NOTE: default assigned first so every path drives rd_mux and no latch is inferred.
        rd_mux = '0;
        if (off == 7'h7F) begin
            rd_mux = {drop_cnt, 15'b0, full, 8'(count)};
        end else if ({1'b0, off} < 8'(count)) begin
            rd_mux = mem[rd_idx];
        end
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_valid_q <= 1'b0;
            in_q       <= '0;
            pop_tog_q  <= 1'b0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
            pk_avail   <= 1'b0;
            rd_data    <= '0;
        end else begin
            in_valid_q <= in_accept;
            in_q       <= in_data;
            pop_tog_q  <= rd_addr[7];
            if (do_push) tail <= tail + AW'(1);
            if (do_pop)  head <= head + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow <= drop;
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
            pk_avail <= !empty;
            rd_data  <= rd_mux;
        end
    end

    // NOTE: storage has no reset; stale words are unreachable because reads are bounded by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= in_q;
    end

endmodule
